mult_hazard_unit: RTL and testbench

//  Stall/bubble generator for the 5-stage pipeline with a multi-cycle EX-stage multiplier.
//  It is the producer side of the bypass network: it stalls whenever the forwarding paths

---
 rtl/mult_hazard_unit.sv | 98 +++++++++
 tb/tb_mult_hazard_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mult_hazard_unit.sv
// rtl/mult_hazard_unit.sv - stall/bubble generator for load-use and multi-cycle MULT hazards
// IDLE/BUSY/LAST FSM tracks a MULT in EX; outputs are Mealy in IDLE and forced non-stall in reset.
module mult_hazard_unit #(
  parameter int MULT_LAT = 4,
  parameter int REG_AW   = 5
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic [REG_AW-1:0] i_rs1_if_id,
  input  logic [REG_AW-1:0] i_rs2_if_id,
  input  logic [REG_AW-1:0] i_rd_id_ex,
  input  logic              i_mem_read_id_ex,
  input  logic              i_mult_id_ex,
  output logic              o_pc_write_en,
  output logic              o_if_id_write_en,
  output logic              o_id_ex_write_en,
  output logic              o_id_ex_bubble,
  output logic              o_ex_mem_bubble,
  output logic              o_mult_busy,
  output logic [2:0]        o_mult_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_LAST} state_t;

  localparam bit         MULT_STALLS = (MULT_LAT >= 2);
  localparam logic [2:0] CNT_INIT    = (MULT_LAT >= 3) ? 3'(MULT_LAT - 2) : 3'd0;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_mult_cnt;
  logic [2:0] w_mult_cnt_nxt;
  logic       w_mult_start;
  logic       w_mult_stall;
  logic       w_load_use;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state    <= S_IDLE;
      r_mult_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_mult_cnt <= w_mult_cnt_nxt;
    end
  end

  // First EX cycle of a MULT is recognised combinationally so it stalls immediately.
  assign w_mult_start = MULT_STALLS && (r_state == S_IDLE) && i_mult_id_ex;

  always_comb begin
    w_state_nxt    = r_state;
    w_mult_cnt_nxt = r_mult_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_mult_start) begin
          if (MULT_LAT >= 3) begin
            w_state_nxt    = S_BUSY;
            w_mult_cnt_nxt = CNT_INIT;
          end else begin
            w_state_nxt    = S_LAST;
            w_mult_cnt_nxt = 3'd0;
          end
        end
      end
      S_BUSY: begin
        if (r_mult_cnt <= 3'd1) begin
          w_state_nxt    = S_LAST;
          w_mult_cnt_nxt = 3'd0;
        end else begin
          w_mult_cnt_nxt = r_mult_cnt - 3'd1;
        end
      end
      S_LAST: begin
        w_state_nxt    = S_IDLE;
        w_mult_cnt_nxt = 3'd0;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_mult_cnt_nxt = 3'd0;
      end
    endcase
  end

  always_comb begin
    w_mult_stall = i_arst_n && (w_mult_start || (r_state == S_BUSY));
    w_load_use   = i_arst_n && !w_mult_stall && i_mem_read_id_ex &&
                   (i_rd_id_ex != '0) &&
                   ((i_rd_id_ex == i_rs1_if_id) || (i_rd_id_ex == i_rs2_if_id));

    o_pc_write_en    = !(w_mult_stall || w_load_use);
    o_if_id_write_en = !(w_mult_stall || w_load_use);
    o_id_ex_write_en = !w_mult_stall;
    o_id_ex_bubble   = w_load_use;
    o_ex_mem_bubble  = w_mult_stall;
    o_mult_busy      = w_mult_stall;
    o_mult_cnt       = r_mult_cnt;
  end

endmodule

// File: tb/tb_mult_hazard_unit.sv
// tb/tb_mult_hazard_unit.sv - self-checking bench for mult_hazard_unit (MULT_LAT 4, 1 and 2)
// Table vectors, reset corner sequences and random stimulus against a phase-count model.
module tb_mult_hazard_unit;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       mem = 1'b0, mult = 1'b0;

  logic [2:0] pc_we, ifid_we, idex_we, idb, exb, busy;
  logic [2:0] cnt [3];

  int errors = 0;
  int checks = 0;
  int lat [3] = '{4, 1, 2};
  int ph  [3] = '{-1, -1, -1};

  always #5 clk = ~clk;

  mult_hazard_unit #(.MULT_LAT(4), .REG_AW(5)) u_lat4 (
    .i_clk(clk), .i_arst_n(arst_n), .i_rs1_if_id(rs1), .i_rs2_if_id(rs2),
    .i_rd_id_ex(rd), .i_mem_read_id_ex(mem), .i_mult_id_ex(mult),
    .o_pc_write_en(pc_we[0]), .o_if_id_write_en(ifid_we[0]), .o_id_ex_write_en(idex_we[0]),
    .o_id_ex_bubble(idb[0]), .o_ex_mem_bubble(exb[0]), .o_mult_busy(busy[0]), .o_mult_cnt(cnt[0]));

  mult_hazard_unit #(.MULT_LAT(1), .REG_AW(5)) u_lat1 (
    .i_clk(clk), .i_arst_n(arst_n), .i_rs1_if_id(rs1), .i_rs2_if_id(rs2),
    .i_rd_id_ex(rd), .i_mem_read_id_ex(mem), .i_mult_id_ex(mult),
    .o_pc_write_en(pc_we[1]), .o_if_id_write_en(ifid_we[1]), .o_id_ex_write_en(idex_we[1]),
    .o_id_ex_bubble(idb[1]), .o_ex_mem_bubble(exb[1]), .o_mult_busy(busy[1]), .o_mult_cnt(cnt[1]));

  mult_hazard_unit #(.MULT_LAT(2), .REG_AW(5)) u_lat2 (
    .i_clk(clk), .i_arst_n(arst_n), .i_rs1_if_id(rs1), .i_rs2_if_id(rs2),
    .i_rd_id_ex(rd), .i_mem_read_id_ex(mem), .i_mult_id_ex(mult),
    .o_pc_write_en(pc_we[2]), .o_if_id_write_en(ifid_we[2]), .o_id_ex_write_en(idex_we[2]),
    .o_id_ex_bubble(idb[2]), .o_ex_mem_bubble(exb[2]), .o_mult_busy(busy[2]), .o_mult_cnt(cnt[2]));

  // Packed view: {pc_we, if_id_we, id_ex_we, id_ex_bubble, ex_mem_bubble, mult_busy, mult_cnt}
  function automatic logic [8:0] got(int i);
    return {pc_we[i], ifid_we[i], idex_we[i], idb[i], exb[i], busy[i], cnt[i]};
  endfunction

  // Model phase p = cycles since the MULT entered EX (-1 = no MULT in flight).
  // Phases 0..lat-2 stall; phase lat-1 is the release cycle.
  function automatic logic [8:0] model_out(int p, int l);
    bit st, lu;
    int c;
    if (!arst_n) return 9'b111000000;
    st = (p >= 0 && p <= l - 2) || (p == -1 && mult && l >= 2);
    lu = !st && mem && (rd != 0) && (rd == rs1 || rd == rs2);
    c  = (p >= 1) ? l - 1 - p : 0;
    return {!(st || lu), !(st || lu), !st, lu, st, st, 3'(c)};
  endfunction

  function automatic int model_next(int p, int l);
    int e;
    e = (p == -1 && mult && l >= 2) ? 0 : p;
    if (e == -1 || e == l - 1) return -1;
    return e + 1;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s lat%0d model", tag, lat[i]), got(i), model_out(ph[i], lat[i]));
  endtask

  task automatic advance_model();
    int nx [3];
    for (int i = 0; i < 3; i++) nx[i] = model_next(ph[i], lat[i]);
    @(posedge clk);
    for (int i = 0; i < 3; i++) ph[i] = nx[i];
  endtask

  task automatic drive(input logic m, input logic mr, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    mult = m; mem = mr; rd = d; rs1 = s1; rs2 = s2;
    #1;
  endtask

  typedef struct {
    logic       m;
    logic       mr;
    logic [4:0] d;
    logic [4:0] s1;
    logic [4:0] s2;
    logic [8:0] exp;
  } vec_t;

  localparam logic [8:0] NS  = 9'b111000000;
  localparam logic [8:0] ST0 = 9'b000011000;
  localparam logic [8:0] ST2 = 9'b000011010;
  localparam logic [8:0] ST1 = 9'b000011001;
  localparam logic [8:0] LU  = 9'b001100000;

  vec_t tab [14];

  initial begin
    tab[0]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ST0};
    tab[1]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ST2};
    tab[2]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ST1};
    tab[3]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, NS};
    tab[4]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ST0};
    tab[5]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ST2};
    tab[6]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, ST1};
    tab[7]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, NS};
    tab[8]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, NS};
    tab[9]  = '{1'b0, 1'b1, 5'd5, 5'd3, 5'd5, LU};
    tab[10] = '{1'b0, 1'b0, 5'd5, 5'd3, 5'd5, NS};
    tab[11] = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, NS};
    tab[12] = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd7, LU};
    tab[13] = '{1'b0, 1'b1, 5'd7, 5'd1, 5'd2, NS};

    // Reset held with a MULT and a load-use pattern present: outputs must be non-stall.
    mult = 1'b1; mem = 1'b0; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd5;
    #12;
    for (int i = 0; i < 3; i++) check($sformatf("reset lat%0d", lat[i]), got(i), NS);
    @(posedge clk);
    mem = 1'b1; mult = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("reset loaduse lat%0d", lat[i]), got(i), NS);
    @(negedge clk);
    mult = 1'b0; mem = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    arst_n = 1'b1;

    for (int t = 0; t < 14; t++) begin
      drive(tab[t].m, tab[t].mr, tab[t].d, tab[t].s1, tab[t].s2);
      check($sformatf("tab[%0d] lat4", t), got(0), tab[t].exp);
      check_model($sformatf("tab[%0d]", t));
      advance_model();
    end

    // Reset pulse during the BUSY cycle with mult_cnt==1.
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    check_model("rst seq c0");
    advance_model();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    check_model("rst seq c1");
    advance_model();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    check("rst seq busy cnt1", got(0), ST1);
    #1 arst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("rst mid-stall lat%0d", lat[i]), got(i), NS);
    for (int i = 0; i < 3; i++) ph[i] = -1;
    @(posedge clk);
    @(negedge clk);
    mult = 1'b0;
    arst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      check($sformatf("post-rst idle c%0d", c), got(0), NS);
      check_model($sformatf("post-rst c%0d", c));
      advance_model();
    end

    // LAT=1 never stalls; LAT=2 stalls one cycle, releases, then a new MULT restarts.
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    check("lat2 stall", got(2), ST0);
    check("lat1 no stall", got(1), NS);
    advance_model();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    check("lat2 last", got(2), NS);
    check("lat1 no stall 2", got(1), NS);
    advance_model();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    check("lat2 restart", got(2), ST0);
    check_model("lat2 restart");
    advance_model();

    for (int n = 0; n < 500; n++) begin
      logic m, mr;
      m  = ($urandom_range(0, 3) == 0);
      mr = m ? 1'b0 : ($urandom_range(0, 2) == 0);
      drive(m, mr, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      check_model($sformatf("rand %0d", n));
      advance_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
